// File: rtl/nvic_pkg.sv
// Shared types and constants for the NVIC interrupt sequencer.
// Imported by the sequencer top and its NVIC port mux.
package nvic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    CLEAR,
    VECTOR,
    ACTIVE
  } state_e;

  localparam logic [1:0] NVIC_EN_ADDR   = 2'b00;
  localparam logic [1:0] NVIC_FLAG_ADDR = 2'b01;

  // Bits 15:12 and 0 have no flag behind them; never write them back as 1.
  localparam logic [15:0] FLAG_KEEP = 16'h0FFE;

  function automatic logic [15:0] flag_clear(
    input logic [15:0] snap,
    input logic [3:0]  code
  );
    return snap & ~(16'h0001 << code) & FLAG_KEEP;
  endfunction

endpackage

// File: rtl/nvic_port_mux.sv
// Two-way select of the single NVIC port between the core bus
// and the sequencer's flag read-modify-write.
module nvic_port_mux
  import nvic_pkg::*;
(
  input  state_e      i_state,
  input  logic [15:0] i_seqDataOut,
  input  logic [1:0]  i_busAddr,
  input  logic [15:0] i_busDataIn,
  input  logic        i_busWrEn,
  output logic [1:0]  o_nvicAddr,
  output logic [15:0] o_nvicDataOut,
  output logic        o_nvicWrEn
);

  always_comb begin
    o_nvicAddr    = i_busAddr;
    o_nvicDataOut = i_busDataIn;
    o_nvicWrEn    = i_busWrEn;
    unique case (i_state)
      READ: begin
        o_nvicAddr    = NVIC_FLAG_ADDR;
        o_nvicDataOut = i_seqDataOut;
        o_nvicWrEn    = 1'b0;
      end
      CLEAR: begin
        o_nvicAddr    = NVIC_FLAG_ADDR;
        o_nvicDataOut = i_seqDataOut;
        o_nvicWrEn    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nvic_sequencer.sv
// Interrupt entry/return sequencer between the NVIC and the core:
// stall, flag clear by read-modify-write, vector redirect, return.
module nvic_sequencer
  import nvic_pkg::*;
#(
  parameter logic [15:0] VEC_BASE  = 16'h0010,
  parameter int unsigned VEC_SHIFT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_intCode,
  input  logic        i_intEn,
  input  logic        i_intMask,
  input  logic        i_coreIdle,
  input  logic [15:0] i_pc,
  input  logic        i_rti,
  output logic        o_stall,
  output logic        o_jumpEn,
  output logic [15:0] o_jumpAddr,
  output logic        o_inIsr,
  input  logic [1:0]  i_busAddr,
  input  logic [15:0] i_busDataIn,
  input  logic        i_busWrEn,
  output logic [15:0] o_busDataOut,
  output logic [1:0]  o_nvicAddr,
  output logic [15:0] o_nvicDataOut,
  output logic        o_nvicWrEn,
  input  logic [15:0] i_nvicDataIn
);

  state_e      state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] savedPc_q, savedPc_d;
  logic [15:0] flagSnap_q, flagSnap_d;
  logic [15:0] vecAddr;

  assign vecAddr = VEC_BASE + (16'(code_q) << VEC_SHIFT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      code_q     <= '0;
      savedPc_q  <= '0;
      flagSnap_q <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      savedPc_q  <= savedPc_d;
      flagSnap_q <= flagSnap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    savedPc_d  = savedPc_q;
    flagSnap_d = flagSnap_q;
    o_stall    = 1'b0;
    o_jumpEn   = 1'b0;
    o_jumpAddr = '0;
    o_inIsr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_intEn && !i_intMask) state_d = WAIT;
      end
      WAIT: begin
        o_stall = 1'b1;
        if (!i_intEn) begin
          state_d = IDLE;
        end else if (i_coreIdle) begin
          code_d    = i_intCode;
          savedPc_d = i_pc;
          state_d   = READ;
        end
      end
      READ: begin
        o_stall    = 1'b1;
        flagSnap_d = i_nvicDataIn;
        state_d    = CLEAR;
      end
      CLEAR: begin
        o_stall = 1'b1;
        state_d = VECTOR;
      end
      VECTOR: begin
        o_stall    = 1'b1;
        o_jumpEn   = 1'b1;
        o_jumpAddr = vecAddr;
        state_d    = ACTIVE;
      end
      ACTIVE: begin
        // No nesting: requests wait until the handler returns.
        o_inIsr = 1'b1;
        if (i_rti) begin
          o_jumpEn   = 1'b1;
          o_jumpAddr = savedPc_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busDataOut = i_nvicDataIn;

  nvic_port_mux u_mux (
    .i_state      (state_q),
    .i_seqDataOut (flag_clear(flagSnap_q, code_q)),
    .i_busAddr    (i_busAddr),
    .i_busDataIn  (i_busDataIn),
    .i_busWrEn    (i_busWrEn),
    .o_nvicAddr   (o_nvicAddr),
    .o_nvicDataOut(o_nvicDataOut),
    .o_nvicWrEn   (o_nvicWrEn)
  );

endmodule

// File: tb/tb_nvic_sequencer.sv
// Bench for nvic_sequencer: directed vector table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_nvic_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_intCode;
  logic        i_intEn;
  logic        i_intMask;
  logic        i_coreIdle;
  logic [15:0] i_pc;
  logic        i_rti;
  logic        o_stall;
  logic        o_jumpEn;
  logic [15:0] o_jumpAddr;
  logic        o_inIsr;
  logic [1:0]  i_busAddr;
  logic [15:0] i_busDataIn;
  logic        i_busWrEn;
  logic [15:0] o_busDataOut;
  logic [1:0]  o_nvicAddr;
  logic [15:0] o_nvicDataOut;
  logic        o_nvicWrEn;
  logic [15:0] i_nvicDataIn;

  always #5 i_clk = ~i_clk;

  nvic_sequencer dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_intCode    (i_intCode),
    .i_intEn      (i_intEn),
    .i_intMask    (i_intMask),
    .i_coreIdle   (i_coreIdle),
    .i_pc         (i_pc),
    .i_rti        (i_rti),
    .o_stall      (o_stall),
    .o_jumpEn     (o_jumpEn),
    .o_jumpAddr   (o_jumpAddr),
    .o_inIsr      (o_inIsr),
    .i_busAddr    (i_busAddr),
    .i_busDataIn  (i_busDataIn),
    .i_busWrEn    (i_busWrEn),
    .o_busDataOut (o_busDataOut),
    .o_nvicAddr   (o_nvicAddr),
    .o_nvicDataOut(o_nvicDataOut),
    .o_nvicWrEn   (o_nvicWrEn),
    .i_nvicDataIn (i_nvicDataIn)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 waiting for core, 2..4 the
  // read/clear/redirect cycles, 5 handler running.
  int          m_ph;
  logic [3:0]  m_code;
  logic [15:0] m_pc, m_snap;

  function automatic logic [15:0] m_cleared();
    logic [15:0] r;
    for (int b = 0; b < 16; b++)
      r[b] = (b >= 1 && b <= 11 && b != int'(m_code)) ? m_snap[b] : 1'b0;
    return r;
  endfunction

  task automatic model_check(string tag);
    logic [15:0] ja;
    ja = 16'h0;
    if (m_ph == 4) ja = 16'h0010 + 16'(m_code) * 16'd4;
    if (m_ph == 5 && i_rti) ja = m_pc;
    chk({tag, " stall"}, 16'(o_stall), 16'(m_ph >= 1 && m_ph <= 4));
    chk({tag, " inIsr"}, 16'(o_inIsr), 16'(m_ph == 5));
    chk({tag, " jumpEn"}, 16'(o_jumpEn),
        16'(m_ph == 4 || (m_ph == 5 && i_rti)));
    chk({tag, " jumpAddr"}, o_jumpAddr, ja);
    chk({tag, " busRd"}, o_busDataOut, i_nvicDataIn);
    if (m_ph == 2 || m_ph == 3) begin
      chk({tag, " nvAddr"}, 16'(o_nvicAddr), 16'h1);
      chk({tag, " nvWr"}, 16'(o_nvicWrEn), 16'(m_ph == 3));
      if (m_ph == 3) chk({tag, " nvData"}, o_nvicDataOut, m_cleared());
    end else begin
      chk({tag, " nvAddr"}, 16'(o_nvicAddr), 16'(i_busAddr));
      chk({tag, " nvWr"}, 16'(o_nvicWrEn), 16'(i_busWrEn));
      chk({tag, " nvData"}, o_nvicDataOut, i_busDataIn);
    end
  endtask

  task automatic model_adv();
    if (i_rst) begin
      m_ph = 0; m_code = 0; m_pc = 0; m_snap = 0;
    end else begin
      case (m_ph)
        0: if (i_intEn && !i_intMask) m_ph = 1;
        1: if (!i_intEn) m_ph = 0;
           else if (i_coreIdle) begin
             m_code = i_intCode; m_pc = i_pc; m_ph = 2;
           end
        2: begin m_snap = i_nvicDataIn; m_ph = 3; end
        3: m_ph = 4;
        4: m_ph = 5;
        5: if (i_rti) m_ph = 0;
        default: m_ph = 0;
      endcase
    end
  endtask

  // One model-checked cycle; inputs already driven after a negedge.
  task automatic mcycle(string tag);
    #1;
    model_check(tag);
    @(posedge i_clk);
    model_adv();
    @(negedge i_clk);
  endtask

  task automatic quiet();
    i_rst = 0; i_intEn = 0; i_intCode = 0; i_intMask = 0;
    i_coreIdle = 0; i_pc = 0; i_rti = 0;
    i_busAddr = 0; i_busDataIn = 0; i_busWrEn = 0; i_nvicDataIn = 0;
  endtask

  typedef struct {
    logic        rst, en, mask, idle, rti;
    logic [3:0]  code;
    logic [15:0] pc, nd;
    logic        bfix;
    logic [1:0]  ba;
    logic [15:0] bd;
    logic        bw;
    logic        e_stall, e_jmp, e_isr;
    logic [15:0] e_ja;
    int          e_own;
    logic [15:0] e_nd;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{default:0, rst:1};
    tbl[1]  = '{default:0, en:1, code:4'd7, idle:1, pc:16'h0123};
    tbl[2]  = '{default:0, en:1, code:4'd7, idle:1, pc:16'h0123,
                e_stall:1};
    tbl[3]  = '{default:0, nd:16'hF0FF, bfix:1, ba:2'b00,
                bd:16'h1234, bw:1, e_stall:1, e_own:1};
    tbl[4]  = '{default:0, en:1, code:4'd7, nd:16'h5555, bfix:1,
                bd:16'hFFFF, bw:1, e_stall:1, e_own:2, e_nd:16'h007E};
    tbl[5]  = '{default:0, e_stall:1, e_jmp:1, e_ja:16'h002C};
    tbl[6]  = '{default:0, en:1, code:4'd9, e_isr:1};
    tbl[7]  = '{default:0, en:1, code:4'd9, rti:1, e_isr:1,
                e_jmp:1, e_ja:16'h0123};
    tbl[8]  = '{default:0, en:1, code:4'd9};
    tbl[9]  = '{default:0, e_stall:1};
    tbl[10] = '{default:0};
    tbl[11] = '{default:0, en:1, code:4'd3, mask:1};
    tbl[12] = '{default:0, en:1, code:4'd3, mask:1};
    tbl[13] = '{default:0, bfix:1, ba:2'b00, bd:16'h0FFE, bw:1};
    tbl[14] = '{default:0, rti:1};

    quiet();
    i_rst = 1;
    @(posedge i_clk);
    model_adv();
    @(negedge i_clk);

    for (int i = 0; i < 15; i++) begin
      string t;
      t = $sformatf("row%0d", i);
      i_rst = tbl[i].rst; i_intEn = tbl[i].en;
      i_intCode = tbl[i].code; i_intMask = tbl[i].mask;
      i_coreIdle = tbl[i].idle; i_pc = tbl[i].pc;
      i_rti = tbl[i].rti; i_nvicDataIn = tbl[i].nd;
      if (tbl[i].bfix) begin
        i_busAddr = tbl[i].ba; i_busDataIn = tbl[i].bd;
        i_busWrEn = tbl[i].bw;
      end else begin
        i_busAddr = 2'($urandom); i_busDataIn = 16'($urandom);
        i_busWrEn = 1'($urandom);
      end
      #1;
      chk({t, " stall"}, 16'(o_stall), 16'(tbl[i].e_stall));
      chk({t, " jumpEn"}, 16'(o_jumpEn), 16'(tbl[i].e_jmp));
      chk({t, " jumpAddr"}, o_jumpAddr, tbl[i].e_ja);
      chk({t, " inIsr"}, 16'(o_inIsr), 16'(tbl[i].e_isr));
      chk({t, " busRd"}, o_busDataOut, tbl[i].nd);
      case (tbl[i].e_own)
        1: begin
          chk({t, " nvAddr"}, 16'(o_nvicAddr), 16'h1);
          chk({t, " nvWr"}, 16'(o_nvicWrEn), 16'h0);
        end
        2: begin
          chk({t, " nvAddr"}, 16'(o_nvicAddr), 16'h1);
          chk({t, " nvWr"}, 16'(o_nvicWrEn), 16'h1);
          chk({t, " nvData"}, o_nvicDataOut, tbl[i].e_nd);
        end
        default: begin
          chk({t, " nvAddr"}, 16'(o_nvicAddr), 16'(i_busAddr));
          chk({t, " nvWr"}, 16'(o_nvicWrEn), 16'(i_busWrEn));
          chk({t, " nvData"}, o_nvicDataOut, i_busDataIn);
        end
      endcase
      @(posedge i_clk);
      model_adv();
      @(negedge i_clk);
    end

    // Core never idles for 5 cycles, then the request is withdrawn.
    quiet();
    i_intEn = 1; i_intCode = 4'd5;
    mcycle("waitA");
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("wait%0d stall", k), 16'(o_stall), 16'h1);
      chk($sformatf("wait%0d nvWr", k), 16'(o_nvicWrEn), 16'h0);
      @(posedge i_clk); model_adv(); @(negedge i_clk);
    end
    i_intEn = 0; i_intCode = 0;
    mcycle("waitDrop");
    #1;
    chk("dropIdle stall", 16'(o_stall), 16'h0);
    chk("dropIdle nvWr", 16'(o_nvicWrEn), 16'h0);
    mcycle("dropIdle");

    // Reset lands during the CLEAR cycle.
    i_intEn = 1; i_intCode = 4'd2; i_coreIdle = 1; i_pc = 16'hBEEF;
    mcycle("rstA"); mcycle("rstB"); mcycle("rstC");
    #1;
    chk("rstClr nvWr", 16'(o_nvicWrEn), 16'h1);
    i_rst = 1;
    mcycle("rstClr");
    quiet();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("postRst%0d stall", k), 16'(o_stall), 16'h0);
      chk($sformatf("postRst%0d jumpEn", k), 16'(o_jumpEn), 16'h0);
      mcycle($sformatf("postRst%0d", k));
    end

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      i_rst = ($urandom_range(0, 299) == 0);
      i_intEn = ($urandom_range(0, 3) != 0);
      i_intCode = i_intEn ? 4'($urandom_range(1, 15)) : 4'd0;
      i_intMask = ($urandom_range(0, 7) == 0);
      i_coreIdle = 1'($urandom);
      i_pc = 16'($urandom);
      i_rti = ($urandom_range(0, 5) == 0);
      i_busAddr = 2'($urandom);
      i_busDataIn = 16'($urandom);
      i_busWrEn = 1'($urandom);
      i_nvicDataIn = 16'($urandom);
      mcycle($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
